// File: rtl/dds_ctrl_pkg.sv
// Shared types and defaults for the DDS frequency-sweep sequencer.
// The dwell helper maps a programmed dwell of zero onto a one-cycle hold.
package dds_ctrl_pkg;

  localparam int FTW_W   = 32;
  localparam int STEPS_W = 16;
  localparam int DWELL_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DWELL
  } sweep_state_e;

  function automatic int unsigned dwell_eff(input int unsigned d);
    return (d == 0) ? 1 : d;
  endfunction

endpackage

// File: rtl/dds_dwell_timer.sv
// Loadable down-counter that measures how long each tuning word is held.
// The counter parks at zero; expire is a combinational view of that condition.
module dds_dwell_timer #(
  parameter int DWELL_W = dds_ctrl_pkg::DWELL_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic               en,
  input  logic [DWELL_W-1:0] load_val,
  output logic               expire
);

  logic [DWELL_W-1:0] cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && !expire) begin
      cnt_q <= cnt_q - DWELL_W'(1);
    end
  end

  assign expire = (cnt_q == '0);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Sweep/hop sequencer driving the DDS tuning word: linear ramps of held FTWs,
// optionally looping phase-continuously, with abort and done signalling.
module dds_sweep_ctrl #(
  parameter int FTW_W   = dds_ctrl_pkg::FTW_W,
  parameter int STEPS_W = dds_ctrl_pkg::STEPS_W,
  parameter int DWELL_W = dds_ctrl_pkg::DWELL_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [FTW_W-1:0]   io_cfg_start_ftw,
  input  logic [FTW_W-1:0]   io_cfg_step_ftw,
  input  logic [STEPS_W-1:0] io_cfg_num_steps,
  input  logic [DWELL_W-1:0] io_cfg_dwell,
  input  logic               io_cfg_repeat,
  input  logic               io_start_valid,
  output logic               io_start_ready,
  input  logic               io_abort,
  output logic [FTW_W-1:0]   io_ftw,
  output logic               io_ftw_load,
  output logic               io_phase_clr,
  output logic               io_busy,
  output logic               io_done
);

  import dds_ctrl_pkg::*;

  sweep_state_e state_q, state_d;

  logic [FTW_W-1:0]        cfg_start_q;
  logic signed [FTW_W-1:0] cfg_step_q;
  logic [STEPS_W-1:0]      cfg_steps_q;
  logic [DWELL_W-1:0]      cfg_dwell_q;
  logic                    cfg_repeat_q;

  logic [FTW_W-1:0]   ftw_q, ftw_d, ftw_stepped;
  logic [STEPS_W-1:0] step_cnt_q, step_cnt_d;
  logic [DWELL_W-1:0] dwell_reload;
  logic ftw_load_q, ftw_load_d;
  logic phase_clr_q, phase_clr_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic cfg_latch, tmr_load, tmr_en, tmr_expire;

  // Counter value is one less than the hold length so expiry lands on the last held cycle.
  assign dwell_reload = DWELL_W'(dwell_eff(32'(cfg_dwell_q)) - 32'd1);
  assign ftw_stepped  = ftw_q + $unsigned(cfg_step_q);

  dds_dwell_timer #(
    .DWELL_W (DWELL_W)
  ) u_dwell_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (dwell_reload),
    .expire   (tmr_expire)
  );

  always_comb begin
    state_d     = state_q;
    ftw_d       = ftw_q;
    ftw_load_d  = 1'b0;
    phase_clr_d = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    step_cnt_d  = step_cnt_q;
    cfg_latch   = 1'b0;
    tmr_load    = 1'b0;
    tmr_en      = 1'b0;
    case (state_q)
      IDLE: begin
        if (io_start_valid) begin
          cfg_latch = 1'b1;
          state_d   = LOAD;
          busy_d    = 1'b1;
        end
      end
      LOAD: begin
        if (io_abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          ftw_d       = cfg_start_q;
          ftw_load_d  = 1'b1;
          phase_clr_d = 1'b1;
          step_cnt_d  = '0;
          tmr_load    = 1'b1;
          state_d     = DWELL;
        end
      end
      DWELL: begin
        // Abort wins over a dwell expiry in the same cycle.
        if (io_abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (tmr_expire) begin
          if (step_cnt_q != cfg_steps_q) begin
            ftw_d      = ftw_stepped;
            ftw_load_d = 1'b1;
            step_cnt_d = step_cnt_q + STEPS_W'(1);
            tmr_load   = 1'b1;
          end else if (cfg_repeat_q) begin
            ftw_d      = cfg_start_q;
            ftw_load_d = 1'b1;
            step_cnt_d = '0;
            tmr_load   = 1'b1;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          tmr_en = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      ftw_q       <= '0;
      ftw_load_q  <= 1'b0;
      phase_clr_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      step_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      ftw_q       <= ftw_d;
      ftw_load_q  <= ftw_load_d;
      phase_clr_q <= phase_clr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      step_cnt_q  <= step_cnt_d;
    end
  end

  // Shadow configuration is sampled only on the accepting cycle.
  always_ff @(posedge clock) begin
    if (cfg_latch) begin
      cfg_start_q  <= io_cfg_start_ftw;
      cfg_step_q   <= $signed(io_cfg_step_ftw);
      cfg_steps_q  <= io_cfg_num_steps;
      cfg_dwell_q  <= io_cfg_dwell;
      cfg_repeat_q <= io_cfg_repeat;
    end
  end

  assign io_start_ready = (state_q == IDLE);
  assign io_ftw         = ftw_q;
  assign io_ftw_load    = ftw_load_q;
  assign io_phase_clr   = phase_clr_q;
  assign io_busy        = busy_q;
  assign io_done        = done_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Bench for dds_sweep_ctrl: a job-timeline reference model checks every cycle,
// plus a table of directed jobs and hand sequences for repeat, abort and reset.
module tb_dds_sweep_ctrl;

  localparam int FTW_W   = 32;
  localparam int STEPS_W = 16;
  localparam int DWELL_W = 16;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic [FTW_W-1:0]   io_cfg_start_ftw = '0;
  logic [FTW_W-1:0]   io_cfg_step_ftw = '0;
  logic [STEPS_W-1:0] io_cfg_num_steps = '0;
  logic [DWELL_W-1:0] io_cfg_dwell = '0;
  logic               io_cfg_repeat = 1'b0;
  logic               io_start_valid = 1'b0;
  logic               io_start_ready;
  logic               io_abort = 1'b0;
  logic [FTW_W-1:0]   io_ftw;
  logic               io_ftw_load;
  logic               io_phase_clr;
  logic               io_busy;
  logic               io_done;

  dds_sweep_ctrl #(
    .FTW_W   (FTW_W),
    .STEPS_W (STEPS_W),
    .DWELL_W (DWELL_W)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .io_cfg_start_ftw (io_cfg_start_ftw),
    .io_cfg_step_ftw  (io_cfg_step_ftw),
    .io_cfg_num_steps (io_cfg_num_steps),
    .io_cfg_dwell     (io_cfg_dwell),
    .io_cfg_repeat    (io_cfg_repeat),
    .io_start_valid   (io_start_valid),
    .io_start_ready   (io_start_ready),
    .io_abort         (io_abort),
    .io_ftw           (io_ftw),
    .io_ftw_load      (io_ftw_load),
    .io_phase_clr     (io_phase_clr),
    .io_busy          (io_busy),
    .io_done          (io_done)
  );

  always #5 clock = ~clock;

  int     checks = 0;
  int     passes = 0;
  longint cyc = 0;

  // Reference model: a job is a timeline indexed by cycles since acceptance.
  bit          m_ready = 1'b1;
  longint      m_age;
  logic [31:0] m_start, m_step;
  longint      m_n, m_d;
  bit          m_rep;
  logic [31:0] e_ftw = '0;
  bit          e_load, e_clr, e_busy, e_done;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s cycle %0d: got 0x%0h want 0x%0h", name, cyc, act, exp);
  endtask

  task automatic model_edge();
    longint k, idx;
    if (reset) begin
      m_ready = 1'b1; e_ftw = '0;
      e_load = 0; e_clr = 0; e_busy = 0; e_done = 0;
      return;
    end
    e_load = 0; e_clr = 0; e_done = 0;
    if (m_ready) begin
      if (io_start_valid) begin
        m_start = io_cfg_start_ftw;
        m_step  = io_cfg_step_ftw;
        m_n     = longint'(io_cfg_num_steps);
        m_d     = (io_cfg_dwell == 0) ? 1 : longint'(io_cfg_dwell);
        m_rep   = io_cfg_repeat;
        m_ready = 1'b0;
        m_age   = 1;
        e_busy  = 1'b1;
      end
    end else if (io_abort) begin
      m_ready = 1'b1; e_done = 1'b1; e_busy = 1'b0;
    end else begin
      m_age++;
      k = m_age - 2;
      if (!m_rep && k >= (m_n + 1) * m_d) begin
        m_ready = 1'b1; e_done = 1'b1; e_busy = 1'b0;
      end else begin
        idx    = k / m_d;
        if (m_rep) idx = idx % (m_n + 1);
        e_ftw  = m_start + 32'(idx) * m_step;
        e_load = (k % m_d) == 0;
        e_clr  = (k == 0);
        e_busy = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    cyc++;
    @(negedge clock);
    check("ftw", 64'(io_ftw), 64'(e_ftw));
    check("ftw_load", 64'(io_ftw_load), 64'(e_load));
    check("phase_clr", 64'(io_phase_clr), 64'(e_clr));
    check("busy", 64'(io_busy), 64'(e_busy));
    check("done", 64'(io_done), 64'(e_done));
    check("start_ready", 64'(io_start_ready), 64'(m_ready));
  endtask

  task automatic set_cfg(input logic [31:0] s, input logic [31:0] st, input int n, input int d,
                         input bit rep);
    io_cfg_start_ftw = s;
    io_cfg_step_ftw  = st;
    io_cfg_num_steps = STEPS_W'(n);
    io_cfg_dwell     = DWELL_W'(d);
    io_cfg_repeat    = rep;
  endtask

  task automatic run_job(input logic [31:0] s, input logic [31:0] st, input int n, input int d,
                         input bit rep, output logic [31:0] last_ftw, output int loads,
                         output int clrs, output int lat);
    longint f;
    bit     seen;
    for (int g = 0; g < 1000 && !io_start_ready; g++) tick();
    set_cfg(s, st, n, d, rep);
    io_start_valid = 1'b1;
    tick();
    io_start_valid = 1'b0;
    loads = 0; clrs = 0; lat = -1; seen = 0; f = 0;
    for (int g = 0; g < 5000; g++) begin
      tick();
      if (io_ftw_load) begin
        loads++;
        if (!seen) begin seen = 1; f = cyc; end
      end
      if (io_phase_clr) clrs++;
      if (io_done) begin lat = int'(cyc - f); break; end
    end
    if (lat < 0) begin
      checks++;
      $display("FAIL job_timeout cycle %0d: no done within 5000 cycles", cyc);
    end
    last_ftw = io_ftw;
  endtask

  typedef struct {
    logic [31:0] start;
    logic [31:0] step;
    int          n;
    int          d;
    bit          rep;
    logic [31:0] exp_last;
    int          exp_loads;
    int          exp_clrs;
    int          exp_lat;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [31:0] last, hold;
    int loads, clrs, lat, cnt;
    bit found;

    vecs[0] = '{32'h0100_0000, 32'h0010_0000, 3, 4, 1'b0, 32'h0130_0000, 4, 1, 16};
    vecs[1] = '{32'h1234_5678, 32'h0000_0001, 0, 0, 1'b0, 32'h1234_5678, 1, 1, 1};
    vecs[2] = '{32'hFFFF_FFF0, 32'h0000_0020, 2, 1, 1'b0, 32'h0000_0030, 3, 1, 3};
    vecs[3] = '{32'h0000_0030, 32'hFFFF_FFF0, 2, 1, 1'b0, 32'h0000_0010, 3, 1, 3};
    vecs[4] = '{32'h7FFF_FFFF, 32'h0000_0001, 1, 3, 1'b0, 32'h8000_0000, 2, 1, 6};

    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("reset_ready", 64'(io_start_ready), 64'd1);

    for (int i = 0; i < 5; i++) begin
      run_job(vecs[i].start, vecs[i].step, vecs[i].n, vecs[i].d, vecs[i].rep,
              last, loads, clrs, lat);
      check("tbl_last_ftw", 64'(last), 64'(vecs[i].exp_last));
      check("tbl_loads", 64'(loads), 64'(vecs[i].exp_loads));
      check("tbl_phase_clr", 64'(clrs), 64'(vecs[i].exp_clrs));
      check("tbl_done_latency", 64'(lat), 64'(vecs[i].exp_lat));
    end

    // Repeating job: period-4 pattern, single phase clear, then abort mid-dwell.
    set_cfg(32'h0000_1000, 32'h0000_0100, 1, 2, 1'b1);
    io_start_valid = 1'b1;
    tick();
    io_start_valid = 1'b0;
    tick();
    clrs = 0;
    for (int j = 0; j < 12; j++) begin
      if (j > 0) tick();
      check("rep_pattern", 64'(io_ftw), ((j / 2) % 2) ? 64'h1100 : 64'h1000);
      if (io_phase_clr) clrs++;
    end
    check("rep_phase_clr", 64'(clrs), 64'd1);
    tick();
    hold = io_ftw;
    check("rep_wrap_ftw", 64'(hold), 64'h1000);
    io_abort = 1'b1;
    tick();
    io_abort = 1'b0;
    check("abort_done", 64'(io_done), 64'd1);
    check("abort_busy", 64'(io_busy), 64'd0);
    check("abort_ftw_hold", 64'(io_ftw), 64'(hold));
    check("abort_load", 64'(io_ftw_load), 64'd0);
    tick();
    check("abort_done_pulse", 64'(io_done), 64'd0);

    // start_valid held and cfg scrambled during a job.
    set_cfg(32'h0000_0500, 32'h0000_0010, 2, 3, 1'b0);
    io_start_valid = 1'b1;
    tick();
    set_cfg(32'hDEAD_0000, 32'h0BAD_0000, 9, 7, 1'b1);
    for (int j = 0; j < 5; j++) tick();
    io_start_valid = 1'b0;
    check("busy_ignore_ftw", 64'(io_ftw), 64'h510);
    cnt = 0;
    for (int j = 0; j < 12; j++) begin
      tick();
      if (io_done) cnt++;
    end
    check("busy_ignore_done", 64'(cnt), 64'd1);
    check("busy_ignore_last", 64'(io_ftw), 64'h520);

    // Abort landing on the final dwell expiry.
    set_cfg(32'h0000_0A00, 32'h0000_0001, 0, 3, 1'b0);
    io_start_valid = 1'b1;
    tick();
    io_start_valid = 1'b0;
    found = 0;
    for (int g = 0; g < 10 && !found; g++) begin
      tick();
      if (io_ftw_load) found = 1;
    end
    check("abort_exp_load_seen", 64'(found), 64'd1);
    tick();
    tick();
    io_abort = 1'b1;
    tick();
    io_abort = 1'b0;
    check("abort_exp_done", 64'(io_done), 64'd1);
    cnt = 1;
    for (int j = 0; j < 3; j++) begin
      tick();
      if (io_done) cnt++;
    end
    check("abort_exp_one_done", 64'(cnt), 64'd1);

    // Reset in the middle of a dwell, then a normal job.
    set_cfg(32'h0300_0000, 32'h0000_0100, 3, 5, 1'b0);
    io_start_valid = 1'b1;
    tick();
    io_start_valid = 1'b0;
    for (int j = 0; j < 4; j++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_ftw", 64'(io_ftw), 64'd0);
    check("rst_busy", 64'(io_busy), 64'd0);
    check("rst_ready", 64'(io_start_ready), 64'd1);
    run_job(vecs[0].start, vecs[0].step, vecs[0].n, vecs[0].d, vecs[0].rep,
            last, loads, clrs, lat);
    check("rst_job_last", 64'(last), 64'(vecs[0].exp_last));
    check("rst_job_latency", 64'(lat), 64'(vecs[0].exp_lat));

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      set_cfg($urandom, ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 255)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
              $urandom_range(0, 3) == 0);
      io_start_valid = $urandom_range(0, 3) == 0;
      io_abort       = $urandom_range(0, 31) == 0;
      reset          = $urandom_range(0, 255) == 0;
      tick();
    end
    io_start_valid = 1'b0;
    io_abort       = 1'b0;
    reset          = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
